bit_field_changer: RTL

- Sequential, parametrised successor to the single-bit changer.
- Applies one operation to a contiguous bit field of an N-bit operand, one bit per clock:
  - toggle, set, clear, or test;
  - field given by start index and length.
- Uses valid/ready handshakes on input and output, and sits between a request source and a result consumer.
- Keeps the family error rule: an illegal index gives o_ERR=1 and o_out=0.

---
 rtl/bit_field_changer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bit_field_changer.sv
// bit_field_changer: applies toggle/set/clear/test to a contiguous bit field
// of an N-bit operand, one bit per clock, behind valid/ready handshakes.
// An illegal start index or field length returns o_ERR=1 with o_out=0.
module bit_field_changer #(
  parameter int N  = 8,
  parameter int LW = $clog2(N) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_a,
  input  logic [N-1:0]  i_b,
  input  logic [LW-1:0] i_len,
  input  logic [1:0]    i_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [N-1:0]  o_out,
  output logic          o_any,
  output logic          o_ERR
);

  // Pointer width covers indices 0..N-1.
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  // Range-check width: one bit wider than the wider of modulus and length,
  // so start + length can never wrap.
  localparam int SW = (((N - 1) > LW) ? (N - 1) : LW) + 1;
  localparam logic [SW-1:0] N_W = SW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_TOGGLE = 2'b00,
    M_SET    = 2'b01,
    M_CLEAR  = 2'b10,
    M_TEST   = 2'b11
  } mode_t;

  state_t         state;
  mode_t          mode;
  logic [PW-1:0]  ptr;
  logic [LW-1:0]  rem;
  logic [N-1:0]   work;
  logic [N-1:0]   work_next;

  logic [SW-1:0]  mod_ext;
  logic [SW-1:0]  len_ext;
  logic [SW-1:0]  end_ext;
  logic           req_err;
  logic           last;

  // Ready depends on state only, so it never combinationally follows i_valid.
  assign o_ready = (state == IDLE);

  // Legality of the incoming request: sign set, start out of range,
  // empty field, or field running past bit N-1.
  always_comb begin
    mod_ext = SW'(i_b[N-2:0]);
    len_ext = SW'(i_len);
    end_ext = mod_ext + len_ext;
    req_err = i_b[N-1] | (mod_ext >= N_W) | (i_len == '0) | (end_ext > N_W);
  end

  // Working register with the current bit rewritten according to the mode.
  always_comb begin
    // NOTE: default assignment first so every path drives work_next and no latch is inferred.
    work_next = work;
    case (mode)
      M_TOGGLE: work_next[ptr] = ~work[ptr];
      M_SET:    work_next[ptr] = 1'b1;
      M_CLEAR:  work_next[ptr] = 1'b0;
      default:  work_next[ptr] = work[ptr];
    endcase
  end

  // The bit processed this cycle is the last one of the field.
  assign last = (rem == LW'(1));

  // Control FSM and datapath; all outputs are registered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      mode    <= M_TOGGLE;
      ptr     <= '0;
      rem     <= '0;
      work    <= '0;
      o_valid <= 1'b0;
      o_out   <= '0;
      o_any   <= 1'b0;
      o_ERR   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (i_valid) begin
            mode  <= mode_t'(i_mode);
            ptr   <= PW'(i_b[N-2:0]);
            rem   <= i_len;
            work  <= i_a;
            o_any <= 1'b0;
            if (req_err) begin
              state   <= DONE;
              o_out   <= '0;
              o_ERR   <= 1'b1;
              o_valid <= 1'b1;
            end else begin
              state <= RUN;
              o_ERR <= 1'b0;
            end
          end
        end

        RUN: begin
          work <= work_next;
          ptr  <= ptr + PW'(1);
          rem  <= rem - LW'(1);
          if (mode == M_TEST) begin
            o_any <= o_any | work[ptr];
          end
          if (last) begin
            state   <= DONE;
            o_out   <= work_next;
            o_valid <= 1'b1;
          end
        end

        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
